// File: rtl/firebird7_in_gate1_tessent_mbist_ijtag_driver.sv
// IJTAG initiator for the gate1 MBIST SIB/TDR segment: capture/shift/update scans, StableBlock polls and chain resets.
// Optional poll attempt limit with timeout flag: FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN.
module firebird7_in_gate1_tessent_mbist_ijtag_driver #(
   parameter int unsigned MAX_LEN      = 8,
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned POLL_MAX     = 255
) (
   input  logic                         ijtag_tck,
   input  logic                         ijtag_rst,
   input  logic                         req,
   input  logic [1:0]                   req_op,
   input  logic [$clog2(MAX_LEN+1)-1:0] req_len,
   input  logic [MAX_LEN-1:0]           req_wdata,
   output logic                         ack,
   output logic                         busy,
   output logic [MAX_LEN-1:0]           rdata,
   output logic                         timeout,
   output logic                         ijtag_reset,
   output logic                         ijtag_sel,
   output logic                         ijtag_si,
   output logic                         ijtag_ce,
   output logic                         ijtag_se,
   output logic                         ijtag_ue,
   input  logic                         ijtag_so
);
   localparam int unsigned LW = $clog2(MAX_LEN + 1);
   localparam int unsigned IW = $clog2(MAX_LEN);
   localparam int unsigned RW = $clog2(RESET_CYCLES + 1);
   localparam logic [1:0] OP_SCAN = 2'd0;
   localparam logic [1:0] OP_POLL = 2'd1;
   localparam logic [1:0] OP_CRST = 2'd2;

   if (MAX_LEN < 2 || RESET_CYCLES < 1 || POLL_MAX < 1) begin : g_param_check
      $error("firebird7 ijtag driver: MAX_LEN >= 2, RESET_CYCLES >= 1 and POLL_MAX >= 1 required");
   end

   typedef enum logic [2:0] {S_IDLE, S_CAP, S_SHIFT, S_UPD, S_DONE, S_RST, S_GAP} state_t;

   state_t             state;
   logic               is_poll;
   logic               hold;
   logic [LW-1:0]      len;
   logic [LW-1:0]      len_eff;
   logic [IW-1:0]      idx;
   logic [RW-1:0]      rcnt;
   logic [MAX_LEN-1:0] wdata;
   logic [MAX_LEN-1:0] wsh;

`ifdef FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN
   localparam int unsigned PW = $clog2(POLL_MAX + 1);
   logic [PW-1:0] attempts;
`else
   assign timeout = 1'b0;
`endif

   // Zero-length requests scan one bit; oversize requests are clamped to the register width.
   always_comb begin
      len_eff = req_len;
      if (req_len == '0)
         len_eff = LW'(1);
      else if (req_len > LW'(MAX_LEN))
         len_eff = LW'(MAX_LEN);
   end

   always_ff @(posedge ijtag_tck or posedge ijtag_rst) begin
      if (ijtag_rst) begin
         state       <= S_IDLE;
         ack         <= 1'b0;
         busy        <= 1'b0;
         rdata       <= '0;
         ijtag_reset <= 1'b0;
         ijtag_sel   <= 1'b0;
         ijtag_si    <= 1'b0;
         ijtag_ce    <= 1'b0;
         ijtag_se    <= 1'b0;
         ijtag_ue    <= 1'b0;
         is_poll     <= 1'b0;
         hold        <= 1'b0;
         len         <= '0;
         idx         <= '0;
         rcnt        <= '0;
         wdata       <= '0;
         wsh         <= '0;
`ifdef FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN
         attempts    <= '0;
         timeout     <= 1'b0;
`endif
      end else begin
         // Outputs describe the state being entered; pulses default low every cycle.
         ack         <= 1'b0;
         ijtag_sel   <= 1'b0;
         ijtag_si    <= 1'b0;
         ijtag_ce    <= 1'b0;
         ijtag_se    <= 1'b0;
         ijtag_ue    <= 1'b0;
         ijtag_reset <= 1'b1;
         case (state)
            S_IDLE: begin
               if (req && !hold) begin
                  busy    <= 1'b1;
                  rdata   <= '0;
                  is_poll <= (req_op == OP_POLL);
                  idx     <= '0;
`ifdef FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN
                  attempts <= '0;
                  timeout  <= 1'b0;
`endif
                  if (req_op == OP_POLL) begin
                     len   <= LW'(1);
                     wdata <= MAX_LEN'(1);
                     wsh   <= MAX_LEN'(1);
                  end else begin
                     len   <= len_eff;
                     wdata <= req_wdata;
                     wsh   <= req_wdata;
                  end
                  case (req_op)
                     OP_SCAN, OP_POLL: begin
                        state     <= S_CAP;
                        ijtag_sel <= 1'b1;
                        ijtag_ce  <= 1'b1;
                     end
                     OP_CRST: begin
                        state       <= S_RST;
                        rcnt        <= '0;
                        ijtag_reset <= 1'b0;
                     end
                     default: begin
                        state <= S_DONE;
                        ack   <= 1'b1;
                     end
                  endcase
               end else if (!req) begin
                  hold <= 1'b0;
               end
            end
            S_CAP: begin
               state     <= S_SHIFT;
               ijtag_sel <= 1'b1;
               ijtag_se  <= 1'b1;
               ijtag_si  <= wsh[0];
               wsh       <= wsh >> 1;
               idx       <= '0;
            end
            S_SHIFT: begin
               rdata[idx] <= ijtag_so;
               ijtag_sel  <= 1'b1;
               if (LW'(idx) == len - LW'(1)) begin
                  state    <= S_UPD;
                  ijtag_ue <= 1'b1;
               end else begin
                  idx      <= idx + IW'(1);
                  ijtag_se <= 1'b1;
                  ijtag_si <= wsh[0];
                  wsh      <= wsh >> 1;
               end
            end
            S_UPD: begin
               if (!is_poll || rdata[0]) begin
                  state <= S_DONE;
                  ack   <= 1'b1;
               end
`ifdef FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN
               else if (attempts == PW'(POLL_MAX)) begin
                  state   <= S_DONE;
                  ack     <= 1'b1;
                  timeout <= 1'b1;
               end
`endif
               else begin
                  state     <= S_GAP;
                  ijtag_sel <= 1'b1;
`ifdef FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN
                  attempts  <= attempts + PW'(1);
`endif
               end
            end
            S_GAP: begin
               state     <= S_CAP;
               ijtag_sel <= 1'b1;
               ijtag_ce  <= 1'b1;
               wsh       <= wdata;
            end
            S_RST: begin
               if (rcnt == RW'(RESET_CYCLES - 1)) begin
                  state <= S_DONE;
                  ack   <= 1'b1;
               end else begin
                  rcnt        <= rcnt + RW'(1);
                  ijtag_reset <= 1'b0;
               end
            end
            S_DONE: begin
               // A requester still holding req here must drop it before the next command is taken.
               state <= S_IDLE;
               busy  <= 1'b0;
               hold  <= req;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/firebird7_in_gate1_tessent_mbist_ijtag_driver.md
Name: firebird7_in_gate1_tessent_mbist_ijtag_driver

Overview:
- IJTAG initiator for the gate1 MBIST diagnosis-ready SIB/TDR segment and similar 1..MAX_LEN-bit segments.
- Sits between the MBIST controller's sequencing logic and the segment's ijtag_* inputs.
- Accepts one command per req/ack handshake and generates capture, shift and update cycles, or an active-low chain reset.
- Returns the bits captured from ijtag_so; a poll command repeats 1-bit scans until StableBlock reads 1.

Parameters:
- MAX_LEN, 8, maximum scan length in bits (>=2).
- RESET_CYCLES, 4, number of cycles ijtag_reset is held low for a chain-reset command.
- POLL_MAX, 255, maximum poll attempts (used only with the optional feature).

Ports:
- ijtag_tck  in  1  clock; all state is posedge.
- ijtag_rst  in  1  asynchronous, active-high reset.
- req  in  1  command request; held high until ack.
- req_op  in  2  command: 0 = SCAN, 1 = POLL, 2 = CHAIN_RESET, 3 = reserved (acked, no action).
- req_len  in  $clog2(MAX_LEN+1)  SCAN length; 0 is treated as 1, values above MAX_LEN are clamped to MAX_LEN.
- req_wdata  in  MAX_LEN  shift-in data, LSB shifted first.
- ack  out  1  one-cycle completion pulse.
- busy  out  1  high from command acceptance until the ack cycle, inclusive.
- rdata  out  MAX_LEN  captured bits; rdata[0] is the first so bit; valid from ack until the next accept.
- timeout  out  1  POLL ended without StableBlock = 1 (optional feature only; tied 0 otherwise).
- ijtag_reset  out  1  active-low segment reset.
- ijtag_sel  out  1  segment select.
- ijtag_si  out  1  scan data to the segment.
- ijtag_ce  out  1  capture enable.
- ijtag_se  out  1  shift enable.
- ijtag_ue  out  1  update enable.
- ijtag_so  in  1  segment scan out (retimed by a low-phase latch in the segment).

Behaviour:
- Reset values:
  - ijtag_reset = 0 while ijtag_rst is high, then 1 on the first posedge after ijtag_rst falls.
  - ack, busy, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, timeout = 0; rdata = 0; FSM = IDLE.
- All ijtag_* outputs are registered on posedge. The segment samples ce/se at the next posedge and ue at the following negedge.
- FSM states: IDLE, CAP, SHIFT, UPD, DONE, RST, GAP.
- IDLE: if req && !ack, latch op, len and wdata, set busy, and go to:
  - CAP for SCAN or POLL (POLL forces len = 1, wdata[0] = 1).
  - RST for CHAIN_RESET.
  - DONE for the reserved op.
- CAP (1 cycle): sel = 1, ce = 1.
- SHIFT (len cycles): sel = 1, se = 1, si = wdata[i] for i = 0..len-1. On each posedge in SHIFT, sample ijtag_so into rdata[i]. Bits at or above len read 0.
- UPD (1 cycle): sel = 1, ue = 1.
- After UPD:
  - SCAN goes to DONE.
  - POLL goes to DONE if rdata[0] = 1; otherwise goes to GAP.
- GAP (1 cycle, all enables 0) returns to CAP and increments the attempt counter.
- RST: ijtag_reset = 0 for RESET_CYCLES cycles with sel/ce/se/ue = 0, then 1, then DONE.
- DONE: ack = 1 for one cycle, busy stays 1, then IDLE. A req still high in the cycle after ack is not treated as a new command until it has dropped for at least one cycle.
- Scan latency: len + 3 cycles from accept to ack (CAP + SHIFT + UPD + DONE).
- Mutual exclusion: ce, se and ue are never high together, and all three are 0 outside CAP/SHIFT/UPD.
- ijtag_rst asserted mid-command: every output returns to its reset value immediately and the in-flight command is dropped with no ack.
- req_op, req_len and req_wdata are ignored while busy.

Optional Feature:
- Macro: FIREBIRD7_IN_GATE1_MBIST_IJTAG_POLL_TIMEOUT_EN.
- Defined:
  - POLL counts attempts. When an attempt after the POLL_MAX-th still reads rdata[0] = 0, the FSM goes to DONE with timeout = 1.
  - timeout holds until the next accept.
- Undefined: POLL retries indefinitely; timeout is tied 0 and the counter is not built.

Test Plan:
- Reset: assert ijtag_rst mid-SHIFT -> all enables 0 immediately, ijtag_reset = 0, no ack; after release ijtag_reset = 1 and busy = 0.
- SCAN len = 2, wdata = 2'b10, on a closed-SIB segment with StableBlock = 1:
  - cycle sequence ce, se, se, ue -> rdata[0] = 1.
  - Segment's sib_latch = 0 after the update (only the SIB is in-path; wdata[0] = 0 shifts into it).
  - ack exactly 5 cycles after accept.
- SCAN len = 1, wdata = 1, then SCAN len = 2, wdata = 2'b11 -> SIB opens, then TDR = 1 and sib_latch = 1; a third SCAN len = 2 reads rdata = 2'b11 (StableBlock = 1, tdr = 1).
- POLL with StableBlock held 0 for 3 attempts then 1 -> exactly 4 CAP pulses with a one-cycle GAP between attempts, ack with rdata[0] = 1, timeout = 0.
- POLL_TIMEOUT_EN, POLL_MAX = 3, StableBlock stuck 0 -> 4 attempts, ack, timeout = 1, rdata[0] = 0.
- CHAIN_RESET with RESET_CYCLES = 4 -> ijtag_reset low for exactly 4 cycles, enables 0 throughout, then ack; a req held high across ack causes no second command.
